w0rm_gpio_in_capture: RTL

Input-side GPIO peripheral that serves the CPU reads of the board switch and mode inputs on gpio_b and gpio_c. It synchronizes and debounces each pin and latches rising and falling edges. It presents the result as four memory-mapped registers on the W0RM data bus and raises a level interrupt on enabled edges. It is the receiving counterpart of the LED output port.

---
 rtl/w0rm_gpio_pkg.sv | 11 +
 rtl/w0rm_gpio_debounce_bit.sv | 52 +++++
 rtl/w0rm_gpio_in_capture.sv | 108 ++++++++++
 3 files changed

// File: rtl/w0rm_gpio_pkg.sv
// Shared register offsets and window size for the W0RM GPIO input capture block.
package w0rm_gpio_pkg;

  localparam logic [3:0] GPIO_REG_DATA  = 4'h0;
  localparam logic [3:0] GPIO_REG_RISE  = 4'h4;
  localparam logic [3:0] GPIO_REG_FALL  = 4'h8;
  localparam logic [3:0] GPIO_REG_IRQEN = 4'hC;

  localparam int unsigned GPIO_WINDOW_BYTES = 16;

endpackage

// File: rtl/w0rm_gpio_debounce_bit.sv
// One GPIO pin: two-flop synchronizer, stability counter, debounced level and edge pulses.
module w0rm_gpio_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ;
  logic             accept;

  assign differ = sync_q[1] ^ deb_q;
  assign accept = differ && (cnt_q == CNT_LAST);

  // The counter only survives while the synchronized level keeps disagreeing.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (accept) begin
      deb_d = sync_q[1];
    end else if (differ) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o  = deb_q;
  assign rise_o = accept & sync_q[1];
  assign fall_o = accept & ~sync_q[1];

endmodule

// File: rtl/w0rm_gpio_in_capture.sv
// GPIO input port: per-pin debounce, sticky edge latches, four-register bus window and level irq.
module w0rm_gpio_in_capture
  import w0rm_gpio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 8,
  parameter int unsigned           DEBOUNCE_CYCLES = 1000,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h8000_0100)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  input  logic                  bus_valid,
  input  logic                  bus_write,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  bus_ack,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_w, rise_p, fall_p;
  logic [DATA_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d, en_q, en_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, irq_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [3:0]            reg_sel;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] wr_bits;

  genvar gi;
  for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_pin
    w0rm_gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .pin_i  (gpio_in[gi]),
      .deb_o  (data_w[gi]),
      .rise_o (rise_p[gi]),
      .fall_o (fall_p[gi])
    );
  end

  if (DATA_WIDTH < 32) begin : g_wdata_upper
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:DATA_WIDTH];
  end

  assign wr_bits = bus_wdata[DATA_WIDTH-1:0];
  assign offset  = bus_addr - BASE_ADDR;
  assign reg_sel = offset[3:0] & 4'hC;
  assign hit     = bus_valid && (bus_addr >= BASE_ADDR)
                   && (offset < ADDR_WIDTH'(GPIO_WINDOW_BYTES));

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      GPIO_REG_DATA:  rd_val = data_w;
      GPIO_REG_RISE:  rd_val = rise_q;
      GPIO_REG_FALL:  rd_val = fall_q;
      GPIO_REG_IRQEN: rd_val = en_q;
      default:        rd_val = '0;
    endcase
  end

  // W1C is applied first so that a same-cycle edge pulse wins over the clear.
  always_comb begin
    rise_d  = rise_q;
    fall_d  = fall_q;
    en_d    = en_q;
    rdata_d = '0;
    if (hit && bus_write) begin
      if (reg_sel == GPIO_REG_RISE)  rise_d = rise_q & ~wr_bits;
      if (reg_sel == GPIO_REG_FALL)  fall_d = fall_q & ~wr_bits;
      if (reg_sel == GPIO_REG_IRQEN) en_d   = wr_bits;
    end
    if (hit && !bus_write) begin
      rdata_d[DATA_WIDTH-1:0] = rd_val;
    end
    rise_d = rise_d | rise_p;
    fall_d = fall_d | fall_p;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q  <= '0;
      fall_q  <= '0;
      en_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
      ack_q   <= hit;
      irq_q   <= |((rise_q | fall_q) & en_q);
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign irq       = irq_q;

endmodule
